load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer: computes the effective address, issues one
// word-aligned memory request, then aligns/extends load data for writeback.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [4:0]  rw,
  output logic        wen,
  output logic [31:0] wdata
);

  typedef enum logic [1:0] {IDLE, REQ, FIN} state_t;

  state_t      state;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  ea_lo_q;
  logic [4:0]  rd_q;
  logic [31:0] ea;
  logic        ea_fault;

  function automatic logic detect_fault(input logic st, input logic [2:0] f3,
                                        input logic [1:0] lo);
    logic f;
    case (f3)
      3'b000:  f = 1'b0;
      3'b001:  f = lo[0];
      3'b010:  f = (lo != 2'b00);
      3'b100:  f = st;
      3'b101:  f = st | lo[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] s;
    case (f3)
      3'b000:  s = 4'b0001 << lo;
      3'b001:  s = lo[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {4{d[7:0]}};
      3'b001:  r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    ea       = base + offset;
    ea_fault = detect_fault(is_store, funct3, ea[1:0]);
  end

  // NOTE: all state and outputs use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      ea_lo_q    <= 2'd0;
      rd_q       <= 5'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wstrb  <= 4'd0;
      mem_wdata  <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      rw         <= 5'd0;
      wen        <= 1'b0;
      wdata      <= 32'd0;
    end else begin
      // Completion signals are single-cycle pulses unless re-asserted below.
      done  <= 1'b0;
      fault <= 1'b0;
      wen   <= 1'b0;
      rw    <= 5'd0;
      wdata <= 32'd0;
      case (state)
        IDLE: begin
          if (start) begin
            is_store_q <= is_store;
            funct3_q   <= funct3;
            ea_lo_q    <= ea[1:0];
            rd_q       <= rd;
            busy       <= 1'b1;
            if (ea_fault) begin
              state <= FIN;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {ea[31:2], 2'b00};
              mem_wstrb <= is_store ? store_strb(funct3, ea[1:0]) : 4'b0000;
              mem_wdata <= is_store ? store_lanes(funct3, store_data) : 32'd0;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            state     <= FIN;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wstrb <= 4'd0;
            mem_wdata <= 32'd0;
            done      <= 1'b1;
            if (!is_store_q) begin
              wen   <= 1'b1;
              rw    <= rd_q;
              wdata <= load_extend(funct3_q, ea_lo_q, mem_rdata);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
